ped_req: RTL

PED_REQ -- requirements
Module: ped_req

---
 rtl/ped_req_if.sv | 10 +
 rtl/ped_req.sv | 77 +++++++
 2 files changed

// File: rtl/ped_req_if.sv
// ped_req_if: pedestrian button/controller signals shared by ped_req and its controller.
interface ped_req_if;
    logic       btn;
    logic       P;
    logic       N;
    logic       busy;
    logic [7:0] req_cnt;
    modport master (output btn, P, input N, busy, req_cnt);
    modport slave  (input btn, P, output N, busy, req_cnt);
endinterface

// File: rtl/ped_req.sv
// ped_req: synchronizes and debounces a pedestrian button and issues one request per service with hold-off.
module ped_req #(
    parameter int DEB_N  = 4,
    parameter int HOLD_N = 8
) (
    input logic       clk,
    input logic       rst,
    ped_req_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PEND, SERVE, HOLD} state_t;
    state_t     state;
    logic [1:0] sync;
    logic       lvl;
    logic [3:0] dcnt;
    logic [7:0] hcnt;
    logic       pend;
    logic       press;
    logic [7:0] cnt_inc;
    assign press   = sync[1] & ~lvl & (dcnt == 4'(DEB_N - 1));
    assign cnt_inc = bus.req_cnt + 8'(bus.req_cnt != 8'hff);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync <= '0;
            lvl  <= 1'b0;
            dcnt <= '0;
        end else begin
            sync <= {sync[0], bus.btn};
            if (sync[1] == lvl) dcnt <= '0;
            else if (dcnt == 4'(DEB_N - 1)) begin
                lvl  <= ~lvl;
                dcnt <= '0;
            end else dcnt <= dcnt + 4'd1;
        end
    // Outputs are registered alongside the state so N/busy track PEND/HOLD exactly.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            hcnt        <= '0;
            pend        <= 1'b0;
            bus.N       <= 1'b0;
            bus.busy    <= 1'b0;
            bus.req_cnt <= '0;
        end else
            case (state)
                IDLE:
                    if (press) begin
                        state       <= PEND;
                        bus.N       <= 1'b1;
                        bus.req_cnt <= cnt_inc;
                    end
                PEND:
                    if (bus.P) begin
                        state <= SERVE;
                        bus.N <= 1'b0;
                    end
                SERVE:
                    if (!bus.P) begin
                        state    <= HOLD;
                        bus.busy <= 1'b1;
                        hcnt     <= 8'(HOLD_N - 1);
                    end
                HOLD:
                    if (hcnt == 8'd0) begin
                        bus.busy <= 1'b0;
                        pend     <= 1'b0;
                        if (pend | press) begin
                            state       <= PEND;
                            bus.N       <= 1'b1;
                            bus.req_cnt <= cnt_inc;
                        end else state <= IDLE;
                    end else begin
                        hcnt <= hcnt - 8'd1;
                        if (press) pend <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
endmodule
